// File: rtl/mem_stage_if.sv
// EX->MEM inputs and MEM->IF/WB outputs of the memory stage.
// The master side is the EX stage driving the bus; the slave side is the memory stage.
interface mem_stage_if;
    logic        in_RegWrite;
    logic        in_MemWrite;
    logic        in_MemRead;
    logic        in_MemToReg;
    logic        in_branch;
    logic        in_zero;
    logic [1:0]  in_load_mode;
    logic [4:0]  in_writebackDestination;
    logic [31:0] in_aluResult;
    logic [31:0] in_rt;
    logic [31:0] in_pc;

    logic        pcsrc_out;
    logic [31:0] branch_target_out;
    logic        RegWrite_out;
    logic        MemToReg_out;
    logic [4:0]  writebackDestination_out;
    logic [31:0] aluResult_out;
    logic [31:0] memData_out;
    logic        misalign_err;

    modport master (
        output in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_branch, in_zero,
               in_load_mode, in_writebackDestination, in_aluResult, in_rt, in_pc,
        input  pcsrc_out, branch_target_out, RegWrite_out, MemToReg_out,
               writebackDestination_out, aluResult_out, memData_out, misalign_err
    );

    modport slave (
        input  in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_branch, in_zero,
               in_load_mode, in_writebackDestination, in_aluResult, in_rt, in_pc,
        output pcsrc_out, branch_target_out, RegWrite_out, MemToReg_out,
               writebackDestination_out, aluResult_out, memData_out, misalign_err
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte-lane data memory, extended loads, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the address.
module mem_stage #(
    parameter int MEM_WORDS = 64
) (
    input  logic      clk,
    input  logic      rst,
    mem_stage_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          wr_en;
    logic          rd_en;

    logic          regwrite_q;
    logic          memtoreg_q;
    logic [4:0]    dest_q;
    logic [31:0]   alu_q;
    logic [31:0]   memdata_q;
    logic [31:0]   memdata_d;

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  mode,
                                                input logic [1:0]  ln);
        logic [31:0] sh;
        sh = word >> {ln, 3'b000};
        case (mode)
            2'd0:    extend_load = word;
            2'd1:    extend_load = {{16{sh[15]}}, sh[15:0]};
            2'd2:    extend_load = {{24{sh[7]}}, sh[7:0]};
            default: extend_load = {24'h0, sh[7:0]};
        endcase
    endfunction

    assign bus.pcsrc_out         = bus.in_branch & bus.in_zero;
    assign bus.branch_target_out = bus.in_pc;

    assign idx     = bus.in_aluResult[AW+1:2];
    assign rd_word = mem_q[idx];

    // Natural-alignment masking of the lane offset; trapped accesses never use it.
    always_comb begin
        lane    = bus.in_aluResult[1:0];
        wr_data = {4{bus.in_rt[7:0]}};
        wr_be   = 4'b0001 << lane;
        case (bus.in_load_mode)
            2'd0: begin
                lane    = 2'b00;
                wr_data = bus.in_rt;
                wr_be   = 4'b1111;
            end
            2'd1: begin
                lane    = {bus.in_aluResult[1], 1'b0};
                wr_data = {2{bus.in_rt[15:0]}};
                wr_be   = bus.in_aluResult[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign;
    logic misalign_q;
    logic misalign_d;

    assign misalign = (bus.in_MemRead | bus.in_MemWrite) &
                      (((bus.in_load_mode == 2'd0) && (bus.in_aluResult[1:0] != 2'b00)) ||
                       ((bus.in_load_mode == 2'd1) && bus.in_aluResult[0]));
    assign wr_en      = bus.in_MemWrite & ~misalign;
    assign rd_en      = bus.in_MemRead & ~misalign;
    assign misalign_d = misalign_q | misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign bus.misalign_err = misalign_q;
`else
    assign wr_en            = bus.in_MemWrite;
    assign rd_en            = bus.in_MemRead;
    assign bus.misalign_err = 1'b0;
`endif

    assign memdata_d = rd_en ? extend_load(rd_word, bus.in_load_mode, lane) : 32'h0;

    // Memory is never reset; stores are held off while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            dest_q     <= 5'd0;
            alu_q      <= 32'h0;
            memdata_q  <= 32'h0;
        end else begin
            regwrite_q <= bus.in_RegWrite;
            memtoreg_q <= bus.in_MemToReg;
            dest_q     <= bus.in_writebackDestination;
            alu_q      <= bus.in_aluResult;
            memdata_q  <= memdata_d;
        end
    end

    assign bus.RegWrite_out             = regwrite_q;
    assign bus.MemToReg_out             = memtoreg_q;
    assign bus.writebackDestination_out = dest_q;
    assign bus.aluResult_out            = alu_q;
    assign bus.memData_out              = memdata_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table through a scoreboard plus
// hand-written branch, reset and misalignment sequences.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mis_model = 1'b0;

    mem_stage_if bus ();
    mem_stage #(.MEM_WORDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mw, mr, m2r;
        logic [1:0]  mode;
        logic [4:0]  dest;
        logic [31:0] addr, rt, exp_md;
    } vec_t;

    typedef struct {
        logic        rw, m2r, mis;
        logic [4:0]  dest;
        logic [31:0] alu, md;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic mw, input logic mr, input logic [1:0] mode,
                                input logic [31:0] addr, input logic [31:0] rt,
                                input logic [31:0] exp_md);
        vec_t v;
        v.rw = mr; v.mw = mw; v.mr = mr; v.m2r = mr;
        v.mode = mode; v.dest = addr[4:0] ^ 5'h1F; v.addr = addr; v.rt = rt; v.exp_md = exp_md;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        bus.in_RegWrite = v.rw;  bus.in_MemWrite = v.mw;  bus.in_MemRead = v.mr;
        bus.in_MemToReg = v.m2r; bus.in_load_mode = v.mode;
        bus.in_writebackDestination = v.dest;
        bus.in_aluResult = v.addr; bus.in_rt = v.rt;
`ifdef MEM_MISALIGN_TRAP_EN
        if ((v.mr || v.mw) && (((v.mode == 2'd0) && (v.addr[1:0] != 2'b00)) ||
                               ((v.mode == 2'd1) && v.addr[0])))
            mis_model = 1'b1;
`endif
        e.rw = v.rw; e.m2r = v.m2r; e.dest = v.dest; e.alu = v.addr; e.md = v.exp_md;
        e.mis = mis_model;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", id);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d RegWrite", id), {31'h0, bus.RegWrite_out}, {31'h0, e.rw});
            chk($sformatf("v%0d MemToReg", id), {31'h0, bus.MemToReg_out}, {31'h0, e.m2r});
            chk($sformatf("v%0d dest", id), {27'h0, bus.writebackDestination_out}, {27'h0, e.dest});
            chk($sformatf("v%0d aluResult", id), bus.aluResult_out, e.alu);
            chk($sformatf("v%0d memData", id), bus.memData_out, e.md);
            chk($sformatf("v%0d misalign", id), {31'h0, bus.misalign_err}, {31'h0, e.mis});
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " RegWrite"}, {31'h0, bus.RegWrite_out}, 32'h0);
        chk({tag, " MemToReg"}, {31'h0, bus.MemToReg_out}, 32'h0);
        chk({tag, " dest"}, {27'h0, bus.writebackDestination_out}, 32'h0);
        chk({tag, " aluResult"}, bus.aluResult_out, 32'h0);
        chk({tag, " memData"}, bus.memData_out, 32'h0);
        chk({tag, " misalign"}, {31'h0, bus.misalign_err}, 32'h0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t  v;
        logic [31:0] mis_exp;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_exp = 32'h0000_0000;
`else
        mis_exp = 32'h5566_7788;
`endif
        vecs.push_back(mk(1, 0, 2'd0, 32'd8,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 1, 2'd0, 32'd8,   32'h0,        32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 2'd2, 32'd8,   32'h0,        32'hFFFFFFEF));
        vecs.push_back(mk(0, 1, 2'd3, 32'd11,  32'h0,        32'h000000DE));
        vecs.push_back(mk(0, 1, 2'd1, 32'd10,  32'h0,        32'hFFFFDEAD));
        vecs.push_back(mk(0, 1, 2'd2, 32'd11,  32'h0,        32'hFFFFFFDE));
        vecs.push_back(mk(1, 1, 2'd0, 32'd8,   32'h11223344, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 2'd0, 32'd8,   32'h0,        32'h11223344));
        vecs.push_back(mk(1, 0, 2'd0, 32'd8,   32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(1, 0, 2'd2, 32'd9,   32'hFFFFFF12, 32'h0));
        vecs.push_back(mk(0, 1, 2'd0, 32'd8,   32'h0,        32'hDEAD12EF));
        vecs.push_back(mk(0, 1, 2'd1, 32'd8,   32'h0,        32'h000012EF));
        vecs.push_back(mk(0, 1, 2'd0, 32'd264, 32'h0,        32'hDEAD12EF));
        vecs.push_back(mk(1, 0, 2'd0, 32'd12,  32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 2'd1, 32'd14,  32'h9999ABCD, 32'h0));
        vecs.push_back(mk(0, 1, 2'd0, 32'd12,  32'h0,        32'hABCD0000));
        vecs.push_back(mk(0, 1, 2'd1, 32'd14,  32'h0,        32'hFFFFABCD));
        vecs.push_back(mk(0, 1, 2'd3, 32'd15,  32'h0,        32'h000000AB));
        vecs.push_back(mk(1, 0, 2'd0, 32'd4,   32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 2'd0, 32'd6,   32'h55667788, 32'h0));
        vecs.push_back(mk(0, 1, 2'd0, 32'd4,   32'h0,        mis_exp));
        vecs.push_back(mk(0, 0, 2'd0, 32'd8,   32'h0,        32'h0));

        bus.in_RegWrite = 0; bus.in_MemWrite = 0; bus.in_MemRead = 0; bus.in_MemToReg = 0;
        bus.in_branch = 0; bus.in_zero = 0; bus.in_load_mode = 0;
        bus.in_writebackDestination = 0; bus.in_aluResult = 0; bus.in_rt = 0; bus.in_pc = 0;

        #2 rst = 1'b1;
        #1 chk_outputs_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        bus.in_branch = 1; bus.in_zero = 1; bus.in_pc = 32'd128;
        #1;
        chk("pcsrc taken", {31'h0, bus.pcsrc_out}, 32'h1);
        chk("branch_target", bus.branch_target_out, 32'd128);
        bus.in_zero = 0;
        #1;
        chk("pcsrc not taken", {31'h0, bus.pcsrc_out}, 32'h0);
        bus.in_branch = 0; bus.in_zero = 1; bus.in_pc = 32'h0000_0F00;
        #1;
        chk("pcsrc no branch", {31'h0, bus.pcsrc_out}, 32'h0);
        chk("branch_target 2", bus.branch_target_out, 32'h0000_0F00);
        bus.in_zero = 0;

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        v.rw = 1; v.mw = 0; v.mr = 0; v.m2r = 1; v.mode = 0; v.dest = 5'd5;
        v.addr = 32'd30; v.rt = 32'h0; v.exp_md = 32'h0;
        apply(v, 100);

        #3 rst = 1'b1;
        #1 chk_outputs_zero("async reset");
        mis_model = 1'b0;
        v.rw = 0; v.mw = 1; v.mr = 0; v.m2r = 0; v.mode = 0; v.dest = 0;
        bus.in_MemWrite = 1; bus.in_RegWrite = 1; bus.in_aluResult = 32'd8; bus.in_rt = 32'h0;
        bus.in_load_mode = 2'd0;
        @(posedge clk); #1;
        chk_outputs_zero("held reset");
        rst = 1'b0;

        v.rw = 1; v.mw = 0; v.mr = 1; v.m2r = 1; v.mode = 0; v.dest = 5'd7;
        v.addr = 32'd8; v.rt = 32'h0; v.exp_md = 32'hDEAD12EF;
        apply(v, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
